// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Front end of the 8-bit MIPS core. Fetches instructions over a req/ack
// memory handshake and buffers them in a small prefetch queue. The queue head
// is presented together with its PC and decoded op_code. A jump from decode
// redirects the fetch PC and flushes every queued instruction.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   imem_req_o     fetch request, held until imem_ack_i
//   imem_addr_o    fetch address, stable while a request is outstanding
//   imem_ack_i     memory accepts the request; imem_rdata_i valid this cycle
//   imem_rdata_i   fetched instruction
//   instr_valid_o  queue head valid
//   instr_o        queue head instruction (zero when the queue is empty)
//   op_code_o      top three bits of instr_o
//   pc_out_o       address of the queue head instruction (zero when empty)
//   instr_ready_i  downstream consumes the head this cycle
//   jump_i         redirect request
//   jump_target_i  redirect address
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int unsigned     PC_W     = 8,
   parameter int unsigned     INSTR_W  = 8,
   parameter int unsigned     DEPTH    = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_o,
   output logic [PC_W-1:0]    imem_addr_o,
   input  logic               imem_ack_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic               instr_valid_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [2:0]         op_code_o,
   output logic [PC_W-1:0]    pc_out_o,
   input  logic               instr_ready_i,
   input  logic               jump_i,
   input  logic [PC_W-1:0]    jump_target_i
);

   localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned     CntW     = $clog2(DEPTH + 1);
   localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
   localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);

   // StDrain is the "drop flag": a request is still outstanding but its data
   // belongs to the old instruction stream and must be discarded.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StDrain = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [PC_W-1:0]    addr_q, addr_d;     // address of the current/next request
   logic [PC_W-1:0]    redir_q, redir_d;   // jump target parked while draining

   logic [PC_W-1:0]    q_pc_q    [DEPTH];
   logic [INSTR_W-1:0] q_instr_q [DEPTH];
   logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]    cnt_q, cnt_d;

   logic               head_valid;
   logic               pop;
   logic               push;
   logic [CntW-1:0]    cnt_after_pop;
   logic [CntW-1:0]    cnt_after_push;
   logic [INSTR_W-1:0] head_instr;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   // ---------------------------------------------------------------------------
   // Queue control. A jump overrides both push and pop.
   // ---------------------------------------------------------------------------
   always_comb begin
      head_valid     = (cnt_q != '0);
      pop            = head_valid & instr_ready_i & ~jump_i;
      push           = (state_q == StFetch) & imem_ack_i & ~jump_i;
      cnt_after_pop  = cnt_q - CntW'(pop);
      cnt_after_push = cnt_after_pop + CntW'(push);
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (jump_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         cnt_d = cnt_after_push;
      end
   end

   // Entry storage needs no reset: the head is gated by the occupancy count.
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc_q[wr_ptr_q]    <= addr_q;
         q_instr_q[wr_ptr_q] <= imem_rdata_i;
      end
   end

   // ---------------------------------------------------------------------------
   // Fetch FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         addr_q   <= RESET_PC;
         redir_q  <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         redir_q  <= redir_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Fetch FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      redir_d = redir_q;
      unique case (state_q)
         StIdle: begin
            if (jump_i) begin
               addr_d  = jump_target_i;
               state_d = StFetch;
            end else if (cnt_after_pop < DepthCnt) begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (jump_i) begin
               if (imem_ack_i) begin
                  // Data returning this cycle is stale; restart at the target.
                  addr_d = jump_target_i;
               end else begin
                  // The request cannot be withdrawn: hold the old address and
                  // drop whatever comes back.
                  redir_d = jump_target_i;
                  state_d = StDrain;
               end
            end else if (imem_ack_i) begin
               addr_d = addr_q + 1'b1;
               if (cnt_after_push >= DepthCnt) begin
                  state_d = StIdle;
               end
            end
         end
         StDrain: begin
            if (jump_i) begin
               redir_d = jump_target_i;
            end
            if (imem_ack_i) begin
               addr_d  = jump_i ? jump_target_i : redir_q;
               state_d = StFetch;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Fetch FSM and queue head: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      head_instr    = head_valid ? q_instr_q[rd_ptr_q] : '0;
      imem_req_o    = (state_q != StIdle);
      imem_addr_o   = addr_q;
      instr_valid_o = head_valid;
      instr_o       = head_instr;
      pc_out_o      = head_valid ? q_pc_q[rd_ptr_q] : '0;
      op_code_o     = head_instr[INSTR_W-1 -: 3];
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the 8-bit MIPS core. Fetches 8-bit instructions from instruction memory through a req/ack handshake.
- Buffers fetched instructions in a small prefetch queue and presents them, together with their PC and extracted op_code, to the control unit and datapath.
- Takes the resolved jump back from the decode/execute side, redirects the PC and flushes stale instructions.

Parameters:
- PC_W, 8, program counter and instruction-memory address width
- INSTR_W, 8, instruction width; op_code = instr[INSTR_W-1:INSTR_W-3]
- DEPTH, 2, prefetch queue entries, each holding {pc, instr}
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  PC_W  fetch address
- imem_ack  in  1  memory accepts request; imem_rdata valid in the same cycle
- imem_rdata  in  INSTR_W  fetched instruction
- instr_valid  out  1  queue head valid
- instr  out  INSTR_W  queue head instruction
- op_code  out  3  instr[7:5], drives control unit op_code
- pc_out  out  PC_W  address of queue head instruction
- instr_ready  in  1  downstream consumes the head this cycle
- jump  in  1  redirect request from decode
- jump_target  in  PC_W  redirect address

Interface: one clock, clk; reset rst is asynchronous and active-high. All other inputs are sampled on rising clk.

Behaviour:
- Reset values while rst is high and asynchronously on assertion:
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, op_code=0, pc_out=0.
  - Queue empty, state IDLE, drop flag clear.
- Fetch FSM states: IDLE (no request), FETCH (imem_req=1, result kept), DRAIN (imem_req=1, result discarded).
- Request rule: imem_addr stable while imem_req=1 until imem_ack. At most one request outstanding. A request is never withdrawn before ack.
- IDLE -> FETCH next cycle when occupancy after this cycle's pop is < DEPTH. First request is issued the first cycle after rst deasserts.
- FETCH on imem_ack:
  - Push {imem_addr, imem_rdata}; imem_addr <= imem_addr+1.
  - Stay FETCH if resulting occupancy < DEPTH, else go IDLE.
  - Back-to-back acks give one instruction per cycle.
- Fill latency: a pushed instruction is visible at the head (instr_valid=1) the cycle after its ack when the queue was empty.
- Pop: instr_valid && instr_ready removes the head. Push and pop in the same cycle keep occupancy unchanged.
- op_code is combinationally instr[7:5] of the head. pc_out and instr are held stable while instr_valid && !instr_ready.
- Jump, sampled at an edge, has priority over push and pop:
  - Queue flushed; instr_valid=0 next cycle. A simultaneous pop is irrelevant.
  - Fetch PC <= jump_target.
  - State IDLE: go FETCH with imem_addr=jump_target.
  - State FETCH with imem_ack the same cycle: rdata dropped; go FETCH with imem_addr=jump_target.
  - State FETCH without imem_ack: go DRAIN and keep the old address. On ack, data is dropped, then FETCH at jump_target.
  - Second jump during DRAIN: the latest jump_target wins.
- PC arithmetic is modulo 2^PC_W (8'hFF+1 -> 8'h00). No overflow flag.
- Full queue: no request is issued, so no overflow is possible. Empty queue: instr_ready ignored.
- rst mid-request: imem_req drops immediately. Memory must tolerate request abandonment on reset only.

Test Plan:
- Reset then imem_ack tied 1, instr_ready=1, memory returns addr as data -> imem_req rises 1 cycle after rst release; head shows pc_out 0,1,2… with instr==pc_out, one per cycle.
- instr_ready=0, ack=1 -> exactly 2 acks accepted (addr 0,1), then imem_req=0 with imem_addr=2. Head holds pc_out=0. Raising ready resumes with addr 2.
- Ack delayed 3 cycles per request -> imem_addr constant through the wait. Instructions at 0,1 delivered in order, none duplicated or lost.
- jump=1, jump_target=8'h40 while queue holds pc 5,6 and no fetch outstanding -> next cycle instr_valid=0, imem_addr=8'h40; first delivered pc_out=8'h40.
- jump to 8'h10 while request to addr 7 is pending with ack arriving 2 cycles later -> addr 7 held until ack, its data never appears at head; next request addr 8'h10.
- Fetch from addr 8'hFE with continuous ack -> pc_out sequence FE, FF, 00, 01.
- Assert rst while imem_req=1 -> imem_req=0, instr_valid=0 immediately. After release, fetch restarts at RESET_PC.
